// File: rtl/seg_update_tx.sv
// seg_update_tx: debounced pushbutton -> one 7-segment update strobe per press.
// Ports: clk, reset (sync, active-high), key_n (raw button, active-low),
//   sw[3:0] (hex value), io_flag (1-cycle strobe), seg_out[6:0]
//   (active-low {g,f,e,d,c,b,a}), busy (FSM not idle).
module seg_update_tx #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic [3:0] sw,
    output logic       io_flag,
    output logic [6:0] seg_out,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        FIRE,
        HELD,
        REL_DB
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Two-flop synchronisers; key flops reset to "released".
    logic       key_q1, key_q2;
    logic [3:0] sw_q1, sw_q2;
    logic       key_s;
    logic [3:0] sw_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       seg_q, seg_d;
    logic             flag_q, flag_d;
    logic             busy_q, busy_d;

    assign key_s   = key_q2;
    assign sw_s    = sw_q2;
    assign io_flag = flag_q;
    assign seg_out = seg_q;
    assign busy    = busy_q;

    function automatic logic [6:0] enc(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        flag_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d = PRESS_DB;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_DB: begin
                if (key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    // Capture happens here so seg_out is valid with the strobe.
                    state_d = FIRE;
                    seg_d   = enc(sw_s);
                    flag_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            FIRE: begin
                state_d = HELD;
                cnt_d   = '0;
            end
            HELD: begin
                if (key_s) begin
                    state_d = REL_DB;
                    cnt_d   = CNT_ONE;
                end
            end
            REL_DB: begin
                if (!key_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q1  <= 1'b1;
            key_q2  <= 1'b1;
            sw_q1   <= '0;
            sw_q2   <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            seg_q   <= 7'b1111111;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            key_q1  <= key_n;
            key_q2  <= key_q1;
            sw_q1   <= sw;
            sw_q2   <= sw_q1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
        end
    end

endmodule
